// File: rtl/golden_nonce_reporter.sv
// Buffers golden mining results ({hash, nonce}) in a small circular buffer and
// serves them to the host one 32-bit word per read: nonce first, then hash words 1..8.
module golden_nonce_reporter #(
    parameter int unsigned DEPTH = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         stop,
    input  logic         clr_cnt,
    input  logic         cand_valid,
    input  logic         cand_golden,
    input  logic [31:0]  cand_nonce,
    input  logic [255:0] cand_hash,
    input  logic         rd_req,
    output logic [31:0]  rd_data,
    output logic         rd_valid,
    output logic [31:0]  golden_cnt,
    output logic [15:0]  drop_cnt,
    output logic         buf_empty,
    output logic         buf_full,
    output logic         irq
);

    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = PW + 1;
    localparam int unsigned EW = 288;

    typedef enum logic {
        IDLE,
        SEND
    } state_e;

    state_e          state_q, state_d;
    logic [3:0]      widx_q, widx_d;
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]   count_q, count_d;
    logic [31:0]     rd_data_q, rd_data_d;
    logic            rd_valid_q, rd_valid_d;
    logic [31:0]     golden_cnt_q, golden_cnt_d;
    logic [15:0]     drop_cnt_q, drop_cnt_d;

    logic [EW-1:0]   mem_q [DEPTH];
    logic [EW-1:0]   head_c;
    logic            golden_c;
    logic            push_c;
    logic            pop_c;

    // Next-state logic: buffer pointers, read FSM and statistics counters
    always_comb begin
        state_d      = state_q;
        widx_d       = widx_q;
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        count_d      = count_q;
        rd_data_d    = rd_data_q;
        rd_valid_d   = 1'b0;
        golden_cnt_d = golden_cnt_q;
        drop_cnt_d   = drop_cnt_q;
        push_c       = 1'b0;
        pop_c        = 1'b0;
        golden_c     = cand_valid & cand_golden & ~stop;
        head_c       = mem_q[rd_ptr_q];

        if (stop) begin
            state_d  = IDLE;
            widx_d   = 4'd0;
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            // Admission uses the registered count, so a same-cycle pop never frees a slot
            push_c = golden_c && (count_q < CW'(DEPTH));

            unique case (state_q)
                IDLE: begin
                    if (rd_req) begin
                        rd_valid_d = 1'b1;
                        if (count_q != '0) begin
                            rd_data_d = head_c[31:0];
                            widx_d    = 4'd1;
                            state_d   = SEND;
                        end else begin
                            rd_data_d = 32'hFFFF_FFFF;
                        end
                    end
                end
                SEND: begin
                    if (rd_req) begin
                        rd_valid_d = 1'b1;
                        rd_data_d  = head_c[{widx_q, 5'b0} +: 32];
                        if (widx_q == 4'd8) begin
                            pop_c   = 1'b1;
                            widx_d  = 4'd0;
                            state_d = IDLE;
                        end else begin
                            widx_d = widx_q + 4'd1;
                        end
                    end
                end
            endcase

            if (push_c) wr_ptr_d = wr_ptr_q + PW'(1);
            if (pop_c)  rd_ptr_d = rd_ptr_q + PW'(1);

            unique case ({push_c, pop_c})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase

            if (golden_c) begin
                golden_cnt_d = golden_cnt_q + 32'd1;
                if (!push_c && (drop_cnt_q != 16'hFFFF)) begin
                    drop_cnt_d = drop_cnt_q + 16'd1;
                end
            end
        end

        if (clr_cnt) begin
            golden_cnt_d = 32'd0;
            drop_cnt_d   = 16'd0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            widx_q       <= 4'd0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            rd_data_q    <= 32'd0;
            rd_valid_q   <= 1'b0;
            golden_cnt_q <= 32'd0;
            drop_cnt_q   <= 16'd0;
        end else begin
            state_q      <= state_d;
            widx_q       <= widx_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            rd_data_q    <= rd_data_d;
            rd_valid_q   <= rd_valid_d;
            golden_cnt_q <= golden_cnt_d;
            drop_cnt_q   <= drop_cnt_d;
        end
    end

    // Entry storage carries no reset; validity is tracked by count_q alone
    always_ff @(posedge clk) begin
        if (push_c) begin
            mem_q[wr_ptr_q] <= {cand_hash, cand_nonce};
        end
    end

    assign rd_data    = rd_data_q;
    assign rd_valid   = rd_valid_q;
    assign golden_cnt = golden_cnt_q;
    assign drop_cnt   = drop_cnt_q;
    assign buf_empty  = (count_q == '0);
    assign buf_full   = (count_q == CW'(DEPTH));
    assign irq        = (count_q != '0);

endmodule

// File: tb/tb_golden_nonce_reporter.sv
// Self-checking bench for golden_nonce_reporter: directed table, corner sequences
// and random traffic compared against a queue-based reference model.
module tb_golden_nonce_reporter;

    localparam int unsigned DEPTH = 4;
    localparam logic [255:0] H1 = {32'd8, 32'd7, 32'd6, 32'd5, 32'd4, 32'd3, 32'd2, 32'd1};

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         stop = 1'b0;
    logic         clr_cnt = 1'b0;
    logic         cand_valid = 1'b0;
    logic         cand_golden = 1'b0;
    logic [31:0]  cand_nonce = 32'd0;
    logic [255:0] cand_hash = '0;
    logic         rd_req = 1'b0;
    logic [31:0]  rd_data;
    logic         rd_valid;
    logic [31:0]  golden_cnt;
    logic [15:0]  drop_cnt;
    logic         buf_empty;
    logic         buf_full;
    logic         irq;

    golden_nonce_reporter #(.DEPTH(DEPTH)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .stop       (stop),
        .clr_cnt    (clr_cnt),
        .cand_valid (cand_valid),
        .cand_golden(cand_golden),
        .cand_nonce (cand_nonce),
        .cand_hash  (cand_hash),
        .rd_req     (rd_req),
        .rd_data    (rd_data),
        .rd_valid   (rd_valid),
        .golden_cnt (golden_cnt),
        .drop_cnt   (drop_cnt),
        .buf_empty  (buf_empty),
        .buf_full   (buf_full),
        .irq        (irq)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [31:0]  nonce;
        logic [255:0] hash;
    } entry_t;

    // Reference model: a queue of stored entries plus the position within the head entry
    entry_t      mq[$];
    int          m_pos = 0;
    logic [31:0] m_gcnt = 32'd0;
    logic [15:0] m_dcnt = 16'd0;
    logic        m_valid = 1'b0;
    logic [31:0] m_data = 32'd0;

    typedef struct {
        logic        stp, clr, v, g, r;
        logic [31:0] nonce;
        logic        ev;
        logic [31:0] ed;
        logic [31:0] eg;
        logic [15:0] edr;
        logic        ee, ef;
    } vec_t;

    vec_t tbl[13];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] word_of(input entry_t e, input int k);
        if (k == 0) return e.nonce;
        return 32'(e.hash >> (32 * (k - 1)));
    endfunction

    task automatic model_step(input logic s, c, v, g, input logic [31:0] n,
                              input logic [255:0] h, input logic r);
        int     pre;
        logic   pop;
        entry_t e;
        pre     = mq.size();
        pop     = 1'b0;
        m_valid = 1'b0;
        if (s) begin
            mq.delete();
            m_pos = 0;
        end else begin
            if (r) begin
                m_valid = 1'b1;
                if (pre == 0) begin
                    m_data = 32'hFFFF_FFFF;
                end else begin
                    m_data = word_of(mq[0], m_pos);
                    m_pos++;
                    if (m_pos == 9) begin
                        m_pos = 0;
                        pop   = 1'b1;
                    end
                end
            end
            if (v && g) begin
                m_gcnt = m_gcnt + 32'd1;
                if (pre < int'(DEPTH)) begin
                    e.nonce = n;
                    e.hash  = h;
                    mq.push_back(e);
                end else if (m_dcnt != 16'hFFFF) begin
                    m_dcnt = m_dcnt + 16'd1;
                end
            end
            if (pop) void'(mq.pop_front());
        end
        if (c) begin
            m_gcnt = 32'd0;
            m_dcnt = 16'd0;
        end
    endtask

    // One clock: drive at a falling edge, check the model at the next falling edge
    task automatic step(input logic s, c, v, g, input logic [31:0] n,
                        input logic [255:0] h, input logic r);
        stop = s; clr_cnt = c; cand_valid = v; cand_golden = g;
        cand_nonce = n; cand_hash = h; rd_req = r;
        model_step(s, c, v, g, n, h, r);
        @(negedge clk);
        chk("m_rd_valid", 32'(rd_valid), 32'(m_valid));
        if (m_valid) chk("m_rd_data", rd_data, m_data);
        chk("m_golden_cnt", golden_cnt, m_gcnt);
        chk("m_drop_cnt", 32'(drop_cnt), 32'(m_dcnt));
        chk("m_buf_empty", 32'(buf_empty), 32'(mq.size() == 0));
        chk("m_buf_full", 32'(buf_full), 32'(mq.size() == int'(DEPTH)));
        chk("m_irq", 32'(irq), 32'(mq.size() != 0));
    endtask

    task automatic push(input logic [31:0] n, input logic [255:0] h);
        step(1'b0, 1'b0, 1'b1, 1'b1, n, h, 1'b0);
    endtask

    task automatic rd();
        step(1'b0, 1'b0, 1'b0, 1'b0, 32'd0, '0, 1'b1);
    endtask

    task automatic flush_clear();
        step(1'b1, 1'b1, 1'b0, 1'b0, 32'd0, '0, 1'b0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Directed table: scenario with nonce 12345678 / hash words k, then empty read
        tbl[0] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 32'h1234_5678, 1'b0, 32'd0, 32'd1, 16'd0, 1'b0, 1'b0};
        tbl[1] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'd0, 1'b1, 32'h1234_5678, 32'd1, 16'd0, 1'b0, 1'b0};
        for (int k = 1; k <= 8; k++) begin
            tbl[1 + k] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'd0, 1'b1, 32'(k), 32'd1, 16'd0,
                           (k == 8), 1'b0};
        end
        tbl[10] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'd0, 1'b1, 32'hFFFF_FFFF, 32'd1, 16'd0, 1'b1, 1'b0};
        tbl[11] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'hDEAD_BEEF, 1'b0, 32'd0, 32'd1, 16'd0, 1'b1, 1'b0};
        tbl[12] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0, 32'd0, 16'd0, 1'b1, 1'b0};

        // Reset values before any clock edge
        #3;
        chk("rst_rd_data", rd_data, 32'd0);
        chk("rst_rd_valid", 32'(rd_valid), 32'd0);
        chk("rst_golden_cnt", golden_cnt, 32'd0);
        chk("rst_drop_cnt", 32'(drop_cnt), 32'd0);
        chk("rst_buf_empty", 32'(buf_empty), 32'd1);
        chk("rst_buf_full", 32'(buf_full), 32'd0);
        chk("rst_irq", 32'(irq), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        foreach (tbl[i]) begin
            step(tbl[i].stp, tbl[i].clr, tbl[i].v, tbl[i].g, tbl[i].nonce, H1, tbl[i].r);
            chk($sformatf("tbl%0d_rd_valid", i), 32'(rd_valid), 32'(tbl[i].ev));
            if (tbl[i].ev) chk($sformatf("tbl%0d_rd_data", i), rd_data, tbl[i].ed);
            chk($sformatf("tbl%0d_golden_cnt", i), golden_cnt, tbl[i].eg);
            chk($sformatf("tbl%0d_drop_cnt", i), 32'(drop_cnt), 32'(tbl[i].edr));
            chk($sformatf("tbl%0d_buf_empty", i), 32'(buf_empty), 32'(tbl[i].ee));
            chk($sformatf("tbl%0d_buf_full", i), 32'(buf_full), 32'(tbl[i].ef));
        end

        // Overflow: six pushes into four slots, then drain in order
        flush_clear();
        for (int i = 0; i < 6; i++) push(32'(i), H1);
        chk("ovf_buf_full", 32'(buf_full), 32'd1);
        chk("ovf_drop_cnt", 32'(drop_cnt), 32'd2);
        chk("ovf_golden_cnt", golden_cnt, 32'd6);
        for (int e = 0; e < 4; e++) begin
            rd();
            chk($sformatf("ovf_nonce%0d", e), rd_data, 32'(e));
            for (int w = 0; w < 8; w++) rd();
        end
        chk("ovf_drained", 32'(buf_empty), 32'd1);

        // Push on the same cycle as the ninth read of a full buffer is dropped
        flush_clear();
        for (int i = 0; i < 4; i++) push(32'h100 + 32'(i), H1);
        for (int w = 0; w < 8; w++) rd();
        step(1'b0, 1'b0, 1'b1, 1'b1, 32'hBAD0_0001, H1, 1'b1);
        chk("pp_drop_cnt", 32'(drop_cnt), 32'd1);
        chk("pp_buf_full", 32'(buf_full), 32'd0);
        chk("pp_golden_cnt", golden_cnt, 32'd5);
        for (int w = 0; w < 27; w++) rd();
        chk("pp_three_left", 32'(buf_empty), 32'd1);

        // Stop mid-entry flushes, ignores same-cycle inputs, keeps counters
        flush_clear();
        push(32'hCAFE_0001, H1);
        for (int w = 0; w < 4; w++) rd();
        step(1'b1, 1'b0, 1'b1, 1'b1, 32'hCAFE_0002, H1, 1'b1);
        chk("stop_rd_valid", 32'(rd_valid), 32'd0);
        chk("stop_buf_empty", 32'(buf_empty), 32'd1);
        chk("stop_golden_cnt", golden_cnt, 32'd1);
        rd();
        chk("stop_sentinel", rd_data, 32'hFFFF_FFFF);

        // Random traffic against the model
        for (int i = 0; i < 3000; i++) begin
            step(($urandom_range(0, 99) < 2), ($urandom_range(0, 99) < 2),
                 ($urandom_range(0, 99) < 40), ($urandom_range(0, 99) < 60),
                 $urandom(),
                 {$urandom(), $urandom(), $urandom(), $urandom(),
                  $urandom(), $urandom(), $urandom(), $urandom()},
                 ($urandom_range(0, 99) < 55));
        end

        // Asynchronous reset while sending an entry
        flush_clear();
        push(32'hFACE_0001, H1);
        push(32'hFACE_0002, H1);
        rd();
        rd();
        stop = 1'b0; clr_cnt = 1'b0; cand_valid = 1'b0; cand_golden = 1'b0; rd_req = 1'b0;
        #1 rst_n = 1'b0;
        #1;
        chk("arst_rd_data", rd_data, 32'd0);
        chk("arst_rd_valid", 32'(rd_valid), 32'd0);
        chk("arst_golden_cnt", golden_cnt, 32'd0);
        chk("arst_buf_empty", 32'(buf_empty), 32'd1);
        chk("arst_irq", 32'(irq), 32'd0);
        #4 rst_n = 1'b1;
        @(negedge clk);
        mq.delete();
        m_pos  = 0;
        m_gcnt = 32'd0;
        m_dcnt = 16'd0;
        rd();
        chk("arst_sentinel", rd_data, 32'hFFFF_FFFF);
        push(32'h7777_0000, H1);
        rd();
        chk("arst_fresh_nonce", rd_data, 32'h7777_0000);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/golden_nonce_reporter.md
GOLDEN_NONCE_REPORTER -- requirements
Module: golden_nonce_reporter

Interface
REQ-001 SHALL have parameter DEPTH, default 4, meaning the number of buffered golden entries (power of 2, 2..16).
REQ-002 SHALL have port clk  input  1  single clock; all logic is rising-edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port stop  input  1  synchronous flush of the buffer and the read FSM.
REQ-005 SHALL have port clr_cnt  input  1  synchronous clear of golden_cnt and drop_cnt.
REQ-006 SHALL have port cand_valid  input  1  one-cycle pulse: candidate result valid.
REQ-007 SHALL have port cand_golden  input  1  candidate hash is below target.
REQ-008 SHALL have port cand_nonce  input  32  nonce of the candidate.
REQ-009 SHALL have port cand_hash  input  256  big-endian-word hash of the candidate.
REQ-010 SHALL have port rd_req  input  1  host word-read strobe.
REQ-011 SHALL have port rd_data  output  32  read word.
REQ-012 SHALL have port rd_valid  output  1  rd_data valid, one-cycle pulse.
REQ-013 SHALL have port golden_cnt  output  32  golden candidates seen since clear.
REQ-014 SHALL have port drop_cnt  output  16  golden candidates lost to a full buffer.
REQ-015 SHALL have port buf_empty  output  1  buffer holds no entries.
REQ-016 SHALL have port buf_full  output  1  buffer holds DEPTH entries.
REQ-017 SHALL have port irq  output  1  level-high while the buffer is non-empty.

Function
REQ-018 Each entry SHALL be 288 bits: {cand_hash, cand_nonce}, stored in a circular buffer with wr_ptr, rd_ptr and an occupancy count of width log2(DEPTH)+1.
REQ-019 When cand_valid=1, cand_golden=1, stop=0 and the registered count < DEPTH, the block SHALL write the entry at wr_ptr, and wr_ptr SHALL wrap modulo DEPTH.
REQ-020 When cand_valid=1 and cand_golden=1, golden_cnt SHALL increment by 1, wrapping at 2^32, regardless of whether the entry is stored.
REQ-021 When cand_valid=1, cand_golden=1 and the registered count == DEPTH, the entry SHALL be discarded, and drop_cnt SHALL increment, saturating at 16'hFFFF; a pop in the same cycle does not admit the write.
REQ-022 When cand_valid=1 and cand_golden=0, the candidate SHALL be ignored with no counter change.
REQ-023 The read FSM SHALL have two states, IDLE and SEND, with a 4-bit word index widx.
REQ-024 In IDLE, rd_req=1 with count>0 SHALL register rd_data=nonce of the head entry, pulse rd_valid the next cycle, set widx=1 and enter SEND.
REQ-025 In IDLE, rd_req=1 with count==0 SHALL return rd_data=32'hFFFF_FFFF with rd_valid=1 the next cycle (empty sentinel) and stay in IDLE.
REQ-026 In SEND, rd_req=1 SHALL return hash[32*widx-1 -: 32] (widx=1 gives bits [31:0]; widx=8 gives [255:224]) one cycle later, and widx SHALL increment.
REQ-027 On returning word widx=8, the FSM SHALL pop the head (rd_ptr+1 mod DEPTH, count-1) and return to IDLE.
REQ-028 Read latency SHALL be 1 cycle from rd_req to rd_valid, with back-to-back rd_req allowed, so a full entry takes 9 reads.
REQ-029 A push and a pop in the same cycle SHALL leave count unchanged and update both pointers.
REQ-030 stop=1 SHALL zero the pointers and count, force IDLE with widx=0 and drive rd_valid=0 next cycle; it SHALL ignore cand_valid and rd_req that cycle and retain the counters.
REQ-031 clr_cnt=1 SHALL zero golden_cnt and drop_cnt, taking priority over a same-cycle increment.
REQ-032 buf_empty, buf_full and irq SHALL be derived combinationally from the registered count.

Reset
REQ-033 When rst_n=0, the block SHALL immediately drive rd_data=0, rd_valid=0, golden_cnt=0, drop_cnt=0, pointers and count=0, state=IDLE and widx=0, giving buf_empty=1, buf_full=0 and irq=0.
REQ-034 Reset mid-entry SHALL discard all entries, with no partial entry retained.
REQ-035 Buffer storage contents SHALL NOT require reset.

Verification
REQ-036 Scenario 1: one golden pulse with nonce=32'h1234_5678 and hash words h_k=k, followed by 9 rd_req -> rd_data sequence 12345678, 1..8, each with rd_valid; then buf_empty=1, irq=0 and golden_cnt=1.
REQ-037 Scenario 2: 6 golden pulses with DEPTH=4 and no reads -> buf_full=1, drop_cnt=2 and golden_cnt=6; reads return nonces 0..3 in order.
REQ-038 Scenario 3: rd_req on an empty buffer -> rd_data=FFFF_FFFF with rd_valid=1 and no state change.
REQ-039 Scenario 4: full buffer with a golden push in the same cycle as the 9th read -> push dropped (drop_cnt+1) and count=3.
REQ-040 Scenario 5: stop asserted after 4 of 9 words are read -> buf_empty=1, FSM in IDLE and counters unchanged; the next rd_req returns the sentinel.
REQ-041 Scenario 6: rst_n pulsed low for half a cycle while in SEND -> all outputs are zero asynchronously with no clock edge needed.
